ssd_scan_ctrl: RTL

Time-multiplexed scan controller for the multi-digit seven-segment display. It sequences one digit at a time with anti-ghosting blank gaps, decodes hex nibbles to active-low segment codes and double-buffers the displayed value. The buffering guarantees that updates from the counter or complex-adder result only take effect at frame boundaries, so the display never tears. It sits between the datapath result registers and the board's anode/segment pins.

---
 rtl/ssd_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit
//               seven-segment display. Lights one digit at a time, inserts
//               an all-off gap between digits to prevent ghosting, decodes
//               hex nibbles to active-low segment codes and double-buffers
//               the displayed value so updates land only on frame boundaries.
//
// Parameters  : DIGITS       - number of digits scanned (1..8)
//               REFRESH_DIV  - clock cycles each digit is lit (>= 2)
//               BLANK_CYCLES - clock cycles all digits are off between digits
//
// Ports       : clock_in   in   system clock, rising edge
//               reset      in   synchronous active-high reset
//               enable     in   scan enable; 0 parks the display blank
//               load       in   one-cycle strobe staging value_in / dp_in
//               value_in   in   hex nibbles, nibble i on digit i
//               dp_in      in   decimal point per digit, 1 = lit
//               an         out  digit anodes, active-low
//               seg        out  segments {g,f,e,d,c,b,a}, active-low
//               dp         out  decimal point, active-low
//               frame_done out  one-cycle pulse on the last cycle of a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    localparam int c_IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_TW-1:0] c_SHOW_LAST  = c_TW'(REFRESH_DIV - 1);
    localparam logic [c_TW-1:0] c_BLANK_LAST = c_TW'(BLANK_CYCLES - 1);
    localparam logic [c_IW-1:0] c_DIGIT_LAST = c_IW'(DIGITS - 1);
    localparam logic [6:0]      c_SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Hex to active-low {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [c_IW-1:0]       r_index;
    logic [c_TW-1:0]       r_tick;
    logic [4*DIGITS-1:0]   r_shadow_val;
    logic [DIGITS-1:0]     r_shadow_dp;
    logic [4*DIGITS-1:0]   r_staged_val;
    logic [DIGITS-1:0]     r_staged_dp;
    logic                  r_pending;
    logic [DIGITS-1:0]     r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_frame_done;

    state_t                w_state_nx;
    logic [c_IW-1:0]       w_index_nx;
    logic [c_TW-1:0]       w_tick_nx;
    logic [4*DIGITS-1:0]   w_shadow_val_nx;
    logic [DIGITS-1:0]     w_shadow_dp_nx;
    logic [4*DIGITS-1:0]   w_staged_val_nx;
    logic [DIGITS-1:0]     w_staged_dp_nx;
    logic                  w_pending_nx;

    logic                  w_show_end;
    logic                  w_blank_end;
    logic                  w_boundary;

    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic [DIGITS-1:0]     w_an_nx;
    logic [6:0]            w_seg_nx;
    logic                  w_dp_nx;
    logic                  w_frame_done_nx;

    assign w_show_end  = (r_state == S_SHOW)  && (r_tick == c_SHOW_LAST);
    assign w_blank_end = (r_state == S_BLANK) && (r_tick == c_BLANK_LAST);
    assign w_boundary  = w_blank_end && (r_index == c_DIGIT_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx      = r_state;
        w_index_nx      = r_index;
        w_tick_nx       = r_tick;
        w_shadow_val_nx = r_shadow_val;
        w_shadow_dp_nx  = r_shadow_dp;
        w_staged_val_nx = r_staged_val;
        w_staged_dp_nx  = r_staged_dp;
        w_pending_nx    = r_pending;

        case (r_state)
            S_SHOW: begin
                if (w_show_end) begin
                    w_state_nx = S_BLANK;
                    w_tick_nx  = '0;
                end else begin
                    w_tick_nx  = r_tick + c_TW'(1);
                end
            end
            S_BLANK: begin
                if (w_blank_end) begin
                    w_tick_nx  = '0;
                    w_index_nx = (r_index == c_DIGIT_LAST) ? '0 : r_index + c_IW'(1);
                    // Enable is only looked at here so a lit digit always
                    // gets its full on-time.
                    if (enable) begin
                        w_state_nx = S_SHOW;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_index_nx = '0;
                    end
                end else begin
                    w_tick_nx  = r_tick + c_TW'(1);
                end
            end
            default: begin
                if (enable) begin
                    w_state_nx = S_SHOW;
                    w_index_nx = '0;
                    w_tick_nx  = '0;
                end
            end
        endcase

        // Frame boundary: commit any staged update.
        if (w_boundary && r_pending) begin
            w_shadow_val_nx = r_staged_val;
            w_shadow_dp_nx  = r_staged_dp;
            w_pending_nx    = 1'b0;
        end

        // A load goes straight to the shadow when nothing is being scanned or
        // when it coincides with the boundary (it then overrides any staged
        // value); otherwise it waits in the staging register.
        if (load) begin
            if ((r_state == S_IDLE) || w_boundary) begin
                w_shadow_val_nx = value_in;
                w_shadow_dp_nx  = dp_in;
                w_pending_nx    = 1'b0;
            end else begin
                w_staged_val_nx = value_in;
                w_staged_dp_nx  = dp_in;
                w_pending_nx    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so the registered pins always
    // agree with the state held in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_an_nx  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_index_nx == c_IW'(i)) begin
                w_nib    = w_shadow_val_nx[4*i +: 4];
                w_dp_bit = w_shadow_dp_nx[i];
                if (w_state_nx == S_SHOW) begin
                    w_an_nx[i] = 1'b0;
                end
            end
        end
    end

    assign w_seg_nx        = (w_state_nx == S_SHOW) ? hex_to_seg(w_nib) : c_SEG_OFF;
    assign w_dp_nx         = (w_state_nx == S_SHOW) ? ~w_dp_bit : 1'b1;
    assign w_frame_done_nx = (w_state_nx == S_BLANK) && (w_tick_nx == c_BLANK_LAST) &&
                             (w_index_nx == c_DIGIT_LAST);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_tick       <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_staged_val <= '0;
            r_staged_dp  <= '0;
            r_pending    <= 1'b0;
            r_an         <= '1;
            r_seg        <= c_SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_index      <= w_index_nx;
            r_tick       <= w_tick_nx;
            r_shadow_val <= w_shadow_val_nx;
            r_shadow_dp  <= w_shadow_dp_nx;
            r_staged_val <= w_staged_val_nx;
            r_staged_dp  <= w_staged_dp_nx;
            r_pending    <= w_pending_nx;
            r_an         <= w_an_nx;
            r_seg        <= w_seg_nx;
            r_dp         <= w_dp_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
